// File: rtl/apb_arbiter2_if.sv
// APB bus bundle shared by both masters and the slave side of apb_arbiter2.
// The master modport drives the request; the slave modport answers it.
`timescale 1ns/1ps

interface apb_arbiter2_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pdata;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH/8-1:0] pstb;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    perr;

    modport master (
        output paddr, pdata, psel, penable, pwrite, pstb,
        input  prdata, pready, perr
    );

    modport slave (
        input  paddr, pdata, psel, penable, pwrite, pstb,
        output prdata, pready, perr
    );
endinterface

// File: rtl/apb_arbiter2.sv
// Two-master / one-slave APB arbiter with round-robin grant and registered slave request.
// Optional access-phase watchdog enabled by defining APB_ARB_TIMEOUT_EN.
`timescale 1ns/1ps

module apb_arbiter2 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic           clk,
    input  logic           rts_n,
    apb_arbiter2_if.slave  m0,
    apb_arbiter2_if.slave  m1,
    apb_arbiter2_if.master s
);
    localparam int STB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("apb_arbiter2: TIMEOUT must be at least 1");
    end

    state_t                state_q;
    logic                  grant_q;
    logic                  last_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pdata_q;
    logic                  pwrite_q;
    logic [STB_WIDTH-1:0]  pstb_q;
    logic                  psel_q;
    logic                  penable_q;

    logic [1:0] req;
    logic       winner;
    logic       in_access;
    logic       slave_done;
    logic       tmo_hit;
    logic       finish;
    logic       xfer_err;

    assign req    = {m1.psel, m0.psel};
    // On a tie the master that did not finish last goes next.
    assign winner = (req == 2'b11) ? ~last_q : req[1];

    assign in_access  = (state_q == ST_ACCESS);
    assign slave_done = in_access && s.pready;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt_q;
    assign tmo_hit = in_access && !s.pready && (tmo_cnt_q == CNT_W'(TIMEOUT));
`else
    assign tmo_hit = 1'b0;
`endif

    assign finish   = slave_done || tmo_hit;
    // A forced completion is always an error; a real one reports the slave's verdict.
    assign xfer_err = slave_done ? s.perr : 1'b1;

    assign m0.pready = finish && !grant_q && m0.psel && m0.penable;
    assign m1.pready = finish &&  grant_q && m1.psel && m1.penable;
    assign m0.perr   = m0.pready && xfer_err;
    assign m1.perr   = m1.pready && xfer_err;
    assign m0.prdata = s.prdata;
    assign m1.prdata = s.prdata;

    assign s.paddr   = paddr_q;
    assign s.pdata   = pdata_q;
    assign s.pwrite  = pwrite_q;
    assign s.pstb    = pstb_q;
    assign s.psel    = psel_q;
    assign s.penable = penable_q;

    always_ff @(posedge clk or negedge rts_n) begin
        if (!rts_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            paddr_q   <= '0;
            pdata_q   <= '0;
            pwrite_q  <= 1'b0;
            pstb_q    <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        grant_q  <= winner;
                        paddr_q  <= winner ? m1.paddr  : m0.paddr;
                        pdata_q  <= winner ? m1.pdata  : m0.pdata;
                        pwrite_q <= winner ? m1.pwrite : m0.pwrite;
                        pstb_q   <= winner ? m1.pstb   : m0.pstb;
                        psel_q   <= 1'b1;
                        state_q  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end
                ST_ACCESS: begin
                    if (finish) begin
                        last_q    <= grant_q;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_arbiter2.sv
// Directed self-checking bench for apb_arbiter2; inputs change and outputs are sampled on negedge.
`timescale 1ns/1ps

module tb_apb_arbiter2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic clk   = 1'b0;
    logic rts_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    apb_arbiter2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
    apb_arbiter2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
    apb_arbiter2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();

    apb_arbiter2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rts_n (rts_n),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        m0_if.paddr = '0; m0_if.pdata = '0; m0_if.psel = 1'b0; m0_if.penable = 1'b0;
        m0_if.pwrite = 1'b0; m0_if.pstb = '0;
        m1_if.paddr = '0; m1_if.pdata = '0; m1_if.psel = 1'b0; m1_if.penable = 1'b0;
        m1_if.pwrite = 1'b0; m1_if.pstb = '0;
        s_if.prdata = '0; s_if.pready = 1'b0; s_if.perr = 1'b0;
    endtask

    task automatic set_m0(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] stb);
        m0_if.paddr = a; m0_if.pdata = d; m0_if.pwrite = w; m0_if.pstb = stb;
        m0_if.psel = 1'b1; m0_if.penable = 1'b1;
    endtask

    task automatic set_m1(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] stb);
        m1_if.paddr = a; m1_if.pdata = d; m1_if.pwrite = w; m1_if.pstb = stb;
        m1_if.psel = 1'b1; m1_if.penable = 1'b1;
    endtask

    task automatic drop_m0();
        m0_if.psel = 1'b0; m0_if.penable = 1'b0;
    endtask

    task automatic drop_m1();
        m1_if.psel = 1'b0; m1_if.penable = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rts_n = 1'b0;
        repeat (2) @(negedge clk);
        rts_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rts_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_if.psel, s_if.penable, s_if.pwrite} !== 3'b000) begin
            n_fail++; $display("FAIL rst_ctrl: got %b want 000", {s_if.psel, s_if.penable, s_if.pwrite});
        end
        n_checks++;
        if ({s_if.paddr, s_if.pdata, s_if.pstb} !== 68'h0) begin
            n_fail++; $display("FAIL rst_regs: got %h/%h/%h want 0", s_if.paddr, s_if.pdata, s_if.pstb);
        end
        n_checks++;
        if ({m0_if.pready, m0_if.perr, m1_if.pready, m1_if.perr} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_resp: got %b want 0000", {m0_if.pready, m0_if.perr, m1_if.pready, m1_if.perr});
        end
        rts_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_if.psel !== 1'b0) begin
            n_fail++; $display("FAIL rst_idle_psel: got %b want 0", s_if.psel);
        end
        $display("txn reset done");
    endtask

    task automatic test_single_write();
        set_m0(32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 4'hF);
        s_if.pready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({s_if.psel, s_if.penable} !== 2'b10) begin
            n_fail++; $display("FAIL wr_setup_ctrl: got %b want 10", {s_if.psel, s_if.penable});
        end
        n_checks++;
        if ({s_if.paddr, s_if.pdata, s_if.pstb, s_if.pwrite} !== {32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1}) begin
            n_fail++; $display("FAIL wr_setup_regs: got %h %h %h %b want 80000010 deadbeef f 1",
                               s_if.paddr, s_if.pdata, s_if.pstb, s_if.pwrite);
        end
        n_checks++;
        if (m0_if.pready !== 1'b0) begin
            n_fail++; $display("FAIL wr_setup_pready: got %b want 0", m0_if.pready);
        end
        m0_if.paddr = 32'h0BAD_0BAD;
        @(negedge clk);
        n_checks++;
        if ({s_if.psel, s_if.penable} !== 2'b11) begin
            n_fail++; $display("FAIL wr_access_ctrl: got %b want 11", {s_if.psel, s_if.penable});
        end
        n_checks++;
        if (s_if.paddr !== 32'h8000_0010) begin
            n_fail++; $display("FAIL wr_addr_hold: got %h want 80000010", s_if.paddr);
        end
        n_checks++;
        if ({m0_if.pready, m0_if.perr, m1_if.pready} !== 3'b100) begin
            n_fail++; $display("FAIL wr_access_resp: got %b want 100", {m0_if.pready, m0_if.perr, m1_if.pready});
        end
        drop_m0();
        @(negedge clk);
        n_checks++;
        if ({s_if.psel, m0_if.pready, m1_if.pready} !== 3'b000) begin
            n_fail++; $display("FAIL wr_back_idle: got %b want 000", {s_if.psel, m0_if.pready, m1_if.pready});
        end
        $display("txn m0 write addr=80000010 data=deadbeef done");
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr;
        logic [1:0]  exp_rdy;
        int          g;
        do_reset();
        set_m0(32'h0000_0100, 32'h1111_1111, 1'b1, 4'hF);
        set_m1(32'h0000_0200, 32'h2222_2222, 1'b0, 4'h3);
        s_if.pready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            g        = (t / 3) % 2;
            exp_addr = (g == 1) ? 32'h0000_0200 : 32'h0000_0100;
            exp_rdy  = (g == 1) ? 2'b10 : 2'b01;
            case (t % 3)
                0: begin
                    n_checks++;
                    if ({s_if.psel, s_if.penable, m1_if.pready, m0_if.pready} !== 4'b1000 || s_if.paddr !== exp_addr) begin
                        n_fail++; $display("FAIL rr_setup t=%0d: got ctrl=%b addr=%h want 1000 %h",
                                           t, {s_if.psel, s_if.penable, m1_if.pready, m0_if.pready}, s_if.paddr, exp_addr);
                    end
                end
                1: begin
                    n_checks++;
                    if ({s_if.psel, s_if.penable} !== 2'b11 || {m1_if.pready, m0_if.pready} !== exp_rdy) begin
                        n_fail++; $display("FAIL rr_access t=%0d: got ctrl=%b rdy=%b want 11 %b",
                                           t, {s_if.psel, s_if.penable}, {m1_if.pready, m0_if.pready}, exp_rdy);
                    end else begin
                        $display("txn rr grant m%0d addr=%h", g, s_if.paddr);
                    end
                end
                default: begin
                    n_checks++;
                    if ({s_if.psel, s_if.penable, m1_if.pready, m0_if.pready} !== 4'b0000) begin
                        n_fail++; $display("FAIL rr_idle t=%0d: got %b want 0000",
                                           t, {s_if.psel, s_if.penable, m1_if.pready, m0_if.pready});
                    end
                end
            endcase
        end
        drop_m0();
        drop_m1();
    endtask

    task automatic test_wait_read();
        s_if.pready = 1'b0;
        set_m1(32'h0000_0300, 32'h0, 1'b0, 4'h0);
        @(negedge clk);
        n_checks++;
        if ({s_if.psel, s_if.pwrite} !== 2'b10 || s_if.paddr !== 32'h0000_0300) begin
            n_fail++; $display("FAIL rd_setup: got psel/pwrite=%b addr=%h want 10 00000300",
                               {s_if.psel, s_if.pwrite}, s_if.paddr);
        end
        set_m0(32'h0000_0400, 32'h0000_0055, 1'b1, 4'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({s_if.penable, m1_if.pready, m0_if.pready} !== 3'b100) begin
                n_fail++; $display("FAIL rd_stall k=%0d: got %b want 100", k, {s_if.penable, m1_if.pready, m0_if.pready});
            end
        end
        @(negedge clk);
        s_if.pready = 1'b1;
        s_if.prdata = 32'h1234_5678;
        #1;
        n_checks++;
        if ({m1_if.pready, m0_if.pready} !== 2'b10 || m1_if.prdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL rd_done: got rdy=%b data=%h want 10 12345678",
                               {m1_if.pready, m0_if.pready}, m1_if.prdata);
        end
        $display("txn m1 read addr=00000300 data=%h", m1_if.prdata);
        drop_m1();
        @(negedge clk);
        n_checks++;
        if ({s_if.psel, m1_if.pready, m0_if.pready} !== 3'b000) begin
            n_fail++; $display("FAIL rd_idle: got %b want 000", {s_if.psel, m1_if.pready, m0_if.pready});
        end
        @(negedge clk);
        n_checks++;
        if (s_if.paddr !== 32'h0000_0400) begin
            n_fail++; $display("FAIL rd_next_m0: got %h want 00000400", s_if.paddr);
        end
        @(negedge clk);
        n_checks++;
        if ({m1_if.pready, m0_if.pready} !== 2'b01) begin
            n_fail++; $display("FAIL rd_m0_done: got %b want 01", {m1_if.pready, m0_if.pready});
        end
        $display("txn m0 write addr=00000400 done");
        drop_m0();
        @(negedge clk);
    endtask

    task automatic test_slave_error();
        s_if.pready = 1'b0;
        s_if.perr   = 1'b1;
        set_m0(32'h0000_0500, 32'h0000_00AA, 1'b1, 4'h1);
        repeat (2) @(negedge clk);
        n_checks++;
        if ({m0_if.pready, m0_if.perr} !== 2'b00) begin
            n_fail++; $display("FAIL err_ignored: got %b want 00", {m0_if.pready, m0_if.perr});
        end
        s_if.pready = 1'b1;
        #1;
        n_checks++;
        if ({m0_if.pready, m0_if.perr} !== 2'b11) begin
            n_fail++; $display("FAIL err_report: got %b want 11", {m0_if.pready, m0_if.perr});
        end
        $display("txn m0 write addr=00000500 error");
        s_if.perr = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({m0_if.pready, m0_if.perr} !== 2'b00) begin
            n_fail++; $display("FAIL err_idle: got %b want 00", {m0_if.pready, m0_if.perr});
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({m0_if.pready, m0_if.perr} !== 2'b10) begin
            n_fail++; $display("FAIL err_clean_next: got %b want 10", {m0_if.pready, m0_if.perr});
        end
        $display("txn m0 write addr=00000500 ok");
        drop_m0();
        @(negedge clk);
    endtask

    task automatic test_timeout();
        s_if.pready = 1'b0;
        s_if.perr   = 1'b0;
        set_m0(32'h0000_0600, 32'h0000_0066, 1'b1, 4'hF);
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({s_if.penable, m0_if.pready, m0_if.perr} !== 3'b100) begin
                n_fail++; $display("FAIL tmo_wait k=%0d: got %b want 100", k, {s_if.penable, m0_if.pready, m0_if.perr});
            end
        end
        @(negedge clk);
`ifdef APB_ARB_TIMEOUT_EN
        n_checks++;
        if ({m0_if.pready, m0_if.perr} !== 2'b11) begin
            n_fail++; $display("FAIL tmo_fire: got %b want 11", {m0_if.pready, m0_if.perr});
        end
        $display("txn m0 write addr=00000600 timeout");
        drop_m0();
        @(negedge clk);
        n_checks++;
        if ({s_if.psel, s_if.penable} !== 2'b00) begin
            n_fail++; $display("FAIL tmo_idle: got %b want 00", {s_if.psel, s_if.penable});
        end
`else
        n_checks++;
        if ({s_if.penable, m0_if.pready} !== 2'b10) begin
            n_fail++; $display("FAIL notmo_5th: got %b want 10", {s_if.penable, m0_if.pready});
        end
        @(negedge clk);
        n_checks++;
        if ({s_if.psel, s_if.penable, m0_if.pready} !== 3'b110) begin
            n_fail++; $display("FAIL notmo_hold: got %b want 110", {s_if.psel, s_if.penable, m0_if.pready});
        end
        s_if.pready = 1'b1;
        #1;
        n_checks++;
        if ({m0_if.pready, m0_if.perr} !== 2'b10) begin
            n_fail++; $display("FAIL notmo_release: got %b want 10", {m0_if.pready, m0_if.perr});
        end
        $display("txn m0 write addr=00000600 done after long wait");
        drop_m0();
        @(negedge clk);
`endif
    endtask

    task automatic test_async_reset();
        s_if.pready = 1'b0;
        set_m1(32'h0000_0700, 32'h0000_0077, 1'b1, 4'hF);
        repeat (2) @(negedge clk);
        set_m0(32'h0000_0800, 32'h0000_0088, 1'b1, 4'hF);
        s_if.pready = 1'b1;
        #1;
        n_checks++;
        if (m1_if.pready !== 1'b1) begin
            n_fail++; $display("FAIL arst_pre: got %b want 1", m1_if.pready);
        end
        rts_n = 1'b0;
        #1;
        n_checks++;
        if ({s_if.psel, s_if.penable, m1_if.pready, m1_if.perr, m0_if.pready} !== 5'b00000) begin
            n_fail++; $display("FAIL arst_ctrl: got %b want 00000",
                               {s_if.psel, s_if.penable, m1_if.pready, m1_if.perr, m0_if.pready});
        end
        n_checks++;
        if ({s_if.paddr, s_if.pdata} !== 64'h0) begin
            n_fail++; $display("FAIL arst_regs: got %h %h want 0", s_if.paddr, s_if.pdata);
        end
        $display("txn async reset during m1 access");
        repeat (2) @(negedge clk);
        rts_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_if.paddr !== 32'h0000_0800 || s_if.psel !== 1'b1) begin
            n_fail++; $display("FAIL arst_tie_m0: got addr=%h psel=%b want 00000800 1", s_if.paddr, s_if.psel);
        end
        @(negedge clk);
        n_checks++;
        if ({m1_if.pready, m0_if.pready} !== 2'b01) begin
            n_fail++; $display("FAIL arst_m0_done: got %b want 01", {m1_if.pready, m0_if.pready});
        end
        $display("txn m0 write addr=00000800 after reset");
        drop_m0();
        drop_m1();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_wait_read();
        test_slave_error();
        test_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
